// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave for the MEM stage: word-addressed storage with
// programmable wait states, stall/ready handshake and access error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        conflict_q;
    logic [31:0] mem [DEPTH];

    logic        req;
    logic        accept;
    logic        fire;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic        acc_write;
    logic        acc_conflict;
    logic        acc_bad;
    logic [AW-1:0] acc_idx;

    assign req = MemRead_i | MemWrite_i;

    // With zero wait states the access completes on the accepting edge, so the
    // live inputs are used instead of the latched copies.
    always_comb begin
        state_next   = state;
        stall_o      = 1'b0;
        accept       = 1'b0;
        fire         = 1'b0;
        acc_addr     = addr_q;
        acc_data     = wdata_q;
        acc_write    = write_q;
        acc_conflict = conflict_q;
        case (state)
            IDLE: begin
                stall_o = req;
                if (req) begin
                    accept       = 1'b1;
                    acc_addr     = addr_i;
                    acc_data     = data_i;
                    acc_write    = MemWrite_i;
                    acc_conflict = MemRead_i & MemWrite_i;
                    if (LATENCY == 0) begin
                        fire       = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (count == 4'd1) begin
                    fire       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign acc_bad = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]) || acc_conflict;
    assign acc_idx = acc_addr[AW+1:2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            count      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            conflict_q <= 1'b0;
            data_o     <= '0;
            ready_o    <= 1'b0;
            err_o      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            state   <= state_next;
            ready_o <= fire;
            err_o   <= fire & acc_bad;
            if (accept) begin
                addr_q     <= addr_i;
                wdata_q    <= data_i;
                write_q    <= MemWrite_i;
                conflict_q <= MemRead_i & MemWrite_i;
                count      <= 4'(LATENCY);
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (fire) begin
                if (acc_bad) begin
                    data_o <= '0;
                end else if (acc_write) begin
                    mem[acc_idx] <= acc_data;
                end else begin
                    data_o <= mem[acc_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one with none,
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_data_mem_responder;
    localparam int DEPTH = 128;

    logic        clk;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        stall [2];
    logic        ready [2];
    logic        err   [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_slow (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
        .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]),
        .stall_o(stall[0]), .ready_o(ready[0]), .err_o(err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_fast (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
        .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]),
        .stall_o(stall[1]), .ready_o(ready[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // ---------------- transaction-level model ----------------
    int          en = 0;
    bit          has_acc   [2];
    int          acc_edge  [2];
    int          last_done [2];
    logic [31:0] exp_data  [2];
    bit          exp_err   [2];
    logic [31:0] mref      [2][DEPTH];
    bit          l_rd [2];
    bit          l_wr [2];
    logic [31:0] l_a  [2];
    logic [31:0] l_d  [2];

    function automatic bit bad_access(bit rv, bit wv, logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH) || (rv && wv);
    endfunction

    task automatic complete(int d, bit rv, bit wv, logic [31:0] a, logic [31:0] dv);
        last_done[d] <= en + 1;
        if (bad_access(rv, wv, a)) begin
            exp_data[d] <= '0;
            exp_err[d]  <= 1'b1;
        end else begin
            exp_err[d] <= 1'b0;
            if (wv) mref[d][a / 4] <= dv;
            else    exp_data[d]    <= mref[d][a / 4];
        end
    endtask

    // Edge en+1: an access accepted at edge A completes at A+lat and the
    // responder is free to accept again from edge A+lat+2.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            en <= 0;
            for (int d = 0; d < 2; d++) begin
                has_acc[d]   <= 1'b0;
                acc_edge[d]  <= 0;
                last_done[d] <= -1;
                exp_data[d]  <= '0;
                exp_err[d]   <= 1'b0;
                for (int i = 0; i < DEPTH; i++) mref[d][i] <= '0;
            end
        end else begin
            en <= en + 1;
            for (int d = 0; d < 2; d++) begin
                if (has_acc[d] && lat(d) != 0 && en + 1 == acc_edge[d] + lat(d))
                    complete(d, l_rd[d], l_wr[d], l_a[d], l_d[d]);
                if ((!has_acc[d] || en + 1 >= acc_edge[d] + lat(d) + 2) && (rd[d] || wr[d])) begin
                    has_acc[d]  <= 1'b1;
                    acc_edge[d] <= en + 1;
                    l_rd[d]     <= rd[d];
                    l_wr[d]     <= wr[d];
                    l_a[d]      <= addr[d];
                    l_d[d]      <= wdat[d];
                    if (lat(d) == 0) complete(d, rd[d], wr[d], addr[d], wdat[d]);
                end
            end
        end
    end

    function automatic bit exp_stall(int d);
        bit busy;
        bit idle_next;
        busy      = has_acc[d] && en >= acc_edge[d] && en < acc_edge[d] + lat(d);
        idle_next = !has_acc[d] || en + 1 >= acc_edge[d] + lat(d) + 2;
        return busy || (idle_next && (rd[d] || wr[d]));
    endfunction

    function automatic bit exp_ready(int d);
        return last_done[d] == en;
    endfunction

    task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, d, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("stall", d, 32'(stall[d]), 32'(exp_stall(d)));
                chk("ready", d, 32'(ready[d]), 32'(exp_ready(d)));
                chk("err",   d, 32'(err[d]),   32'(exp_ready(d) && exp_err[d]));
                chk("data",  d, rdat[d], exp_data[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; holds the request until ready, then drops it.
    task automatic access(int d, bit r, bit w, logic [31:0] a, logic [31:0] dv,
                          output int sc, output logic [31:0] gd, output logic ge);
        int  n;
        bit  seen;
        rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = dv;
        sc = 0; gd = 'x; ge = 1'bx; n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (stall[d]) sc++;
            if (ready[d]) begin
                seen = 1;
                gd   = rdat[d];
                ge   = err[d];
            end
            n++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout dut%0d got=no_ready exp=ready", d);
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          sc;
        logic [31:0] gd;
        logic        ge;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_on = 1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_data",  d, rdat[d], 32'h0);
            chk("rst_stall", d, 32'(stall[d]), 32'h0);
            chk("rst_ready", d, 32'(ready[d]), 32'h0);
        end
        @(posedge clk); #1;

        access(0, 1, 0, 32'h0,   '0, sc, gd, ge);  chk("init_rd0",   0, gd, 32'h0);
        access(0, 1, 0, 32'h1FC, '0, sc, gd, ge);  chk("init_rdtop", 0, gd, 32'h0);

        access(0, 0, 1, 32'h10, 32'hDEADBEEF, sc, gd, ge);
        chk("st_stall_len", 0, sc, 3);
        access(0, 1, 0, 32'h10, '0, sc, gd, ge);
        chk("ld_stall_len", 0, sc, 3);
        chk("ld_data", 0, gd, 32'hDEADBEEF);
        chk("ld_err",  0, 32'(ge), 32'h0);

        access(1, 1, 0, 32'h4, '0, sc, gd, ge);
        chk("fast_stall_len", 1, sc, 1);
        chk("fast_ld0", 1, gd, 32'h0);
        access(1, 0, 1, 32'h4, 32'h12345678, sc, gd, ge);
        access(1, 1, 0, 32'h4, '0, sc, gd, ge);
        chk("fast_ld", 1, gd, 32'h12345678);

        access(0, 0, 1, 32'h13, 32'h11111111, sc, gd, ge);
        chk("misal_err", 0, 32'(ge), 32'h1);
        access(0, 1, 0, 32'(4 * DEPTH), '0, sc, gd, ge);
        chk("oor_err",  0, 32'(ge), 32'h1);
        chk("oor_data", 0, gd, 32'h0);
        access(0, 1, 0, 32'h10, '0, sc, gd, ge);
        chk("reread", 0, gd, 32'hDEADBEEF);

        access(0, 1, 1, 32'h8, 32'hCAFEF00D, sc, gd, ge);
        chk("conf_err", 0, 32'(ge), 32'h1);
        access(0, 1, 0, 32'h8, '0, sc, gd, ge);
        chk("conf_word", 0, gd, 32'h0);
        chk("conf_ok",   0, 32'(ge), 32'h0);

        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        rst = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 0, 32'(stall[0]), 32'h0);
        chk("midrst_ready", 0, 32'(ready[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        access(0, 1, 0, 32'h20, '0, sc, gd, ge);
        chk("midrst_ld", 0, gd, 32'h0);
        access(1, 1, 0, 32'h4, '0, sc, gd, ge);
        chk("midrst_fast", 1, gd, 32'h0);

        for (int k = 0; k < 200; k++) begin
            int          d;
            int          mode;
            bit          r;
            bit          w;
            logic [31:0] a;
            d    = $urandom_range(0, 1);
            mode = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 7)) * 4;
            r    = $urandom_range(0, 1) == 1;
            w    = !r;
            case (mode)
                0: a = a + 32'($urandom_range(1, 3));
                1: a = 32'(4 * DEPTH) + (($urandom() & 32'h0000FFFC) << 2);
                2: begin r = 1; w = 1; end
                3: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                default: ;
            endcase
            access(d, r, w, a, $urandom(), sc, gd, ge);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
